exe_stage_unit: RTL and testbench
=================================

// Module: exe_stage_unit
// PURPOSE
// ARM-subset execute stage: consumes Val1 (Rn) and Val2 (shifter/immediate operand
// generator output) from the ID/EXE boundary, computes the ALU result, and owns the
// architectural NZCV status register. It drives the registered EXE/MEM pipeline
// boundary, with freeze (stall) and flush (bubble) control from the hazard unit.
// PARAMETERS
// DW    32  datapath width (Val1, Val2, result)
// RW    4   destination register index width
// PORTS
// clk           in   1   rising-edge clock
// rst           in   1   asynchronous reset, active-low
// freeze        in   1   hold all EXE/MEM and status state this cycle
// flush         in   1   load bubble into EXE/MEM this cycle; status not updated
// valid_in      in   1   instruction present at ID/EXE boundary
// exe_cmd       in   4   ALU operation code (table below)
// s_in          in   1   update NZCV from this instruction
// val1          in   DW  first operand (Rn)
// val2          in   DW  second operand from operand generator
// st_val_in     in   DW  Rm value carried to MEM for stores
// dest_in       in   RW  writeback register index
// wb_en_in      in   1   writeback enable
// mem_r_en_in   in   1   load
// mem_w_en_in   in   1   store
// valid_out     out  1   EXE/MEM slot holds a real instruction
// alu_res_out   out  DW  registered ALU result / memory address
// st_val_out    out  DW  registered store data
// dest_out      out  RW  registered destination index
// wb_en_out     out  1   registered writeback enable (gated by valid)
// mem_r_en_out  out  1   registered load enable (gated by valid)
// mem_w_en_out  out  1   registered store enable (gated by valid)
// status_out    out  4   {N,Z,C,V} architectural status register
// BEHAVIOUR
// - Reset (rst=0, async): every output and status register = 0; EXE/MEM holds a bubble.
// - exe_cmd: 0001 MOV r=v2 | 1001 MVN r=~v2 | 0010 ADD r=v1+v2 | 0011 ADC r=v1+v2+C
//   0100 SUB r=v1-v2 | 0101 SBC r=v1+~v2+C | 0110 AND | 0111 ORR | 1000 EOR.
//   Any other code: r=0, status never updated. LDR/STR use ADD; CMP=SUB, TST=AND with wb_en_in=0.
// - Arithmetic in DW+1 bits. ADD/ADC: C=carry-out[DW]. SUB/SBC: C=NOT borrow
//   (v1+~v2+1 / v1+~v2+C carry-out). V=signed overflow of the same sum.
// - N=r[DW-1], Z=(r==0) for all defined ops. Logic/move ops leave C,V unchanged.
// - ADC/SBC read C from status_out (current registered value), so back-to-back S-ops
//   see the previous instruction's flags with zero bubbles.
// - Status write on posedge iff valid_in & s_in & ~freeze & ~flush & defined cmd.
// - EXE/MEM register, 1-cycle latency, priority per edge: flush > freeze > load.
//   flush: valid_out, wb_en_out, mem_r_en_out, mem_w_en_out <=0; data fields <=0.
//   freeze: all outputs and status hold. load: capture inputs; control enables
//   captured as (en_in & valid_in). valid_in=0 loads a bubble (same as flush).
// - Reset mid-operation clears in-flight slot immediately; no partial update survives.
// - Combinational paths from inputs to outputs: none; all outputs registered.
// TESTING
// - Reset with freeze=1 asserted -> all outputs 0; release rst, valid ADD 5+7 -> next cycle alu_res_out=12, valid_out=1.
// - SUB s=1 v1=3,v2=3 -> r=0, NZCV=0110; then SUB s=1 v1=0,v2=1 -> r=FFFFFFFF, NZCV=1000.
// - ADD s=1 7FFFFFFF+1 -> NZCV=1001; next ADC s=0 v1=v2=0 with C=0 -> r=0; repeat after FFFFFFFF+1 (C=1) -> ADC 0+0 gives 1.
// - freeze=1 for 3 cycles during ADD s=1 -> outputs and status unchanged; flush=1 with freeze=1 -> bubble loaded, status unchanged.
// - LDR (cmd 0010, mem_r_en_in=1, valid_in=0) -> mem_r_en_out=0, valid_out=0; exe_cmd=1111 s=1 -> r=0, status held.
// - Assert rst mid-stream after AND s=1 -> status_out=0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/exe_stage_unit.sv
`default_nettype none
// ============================================================================
// exe_stage_unit : ARM-subset execute stage with NZCV status and EXE/MEM register
// Rev 1.0
// ============================================================================
module exe_stage_unit #(
  parameter int DW = 32,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          freeze,
  input  logic          flush,
  input  logic          valid_in,
  input  logic [3:0]    exe_cmd,
  input  logic          s_in,
  input  logic [DW-1:0] val1,
  input  logic [DW-1:0] val2,
  input  logic [DW-1:0] st_val_in,
  input  logic [RW-1:0] dest_in,
  input  logic          wb_en_in,
  input  logic          mem_r_en_in,
  input  logic          mem_w_en_in,
  output logic          valid_out,
  output logic [DW-1:0] alu_res_out,
  output logic [DW-1:0] st_val_out,
  output logic [RW-1:0] dest_out,
  output logic          wb_en_out,
  output logic          mem_r_en_out,
  output logic          mem_w_en_out,
  output logic [3:0]    status_out
);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  logic          valid_q;
  logic [DW-1:0] alu_res_q;
  logic [DW-1:0] st_val_q;
  logic [RW-1:0] dest_q;
  logic          wb_en_q;
  logic          mem_r_en_q;
  logic          mem_w_en_q;
  logic [3:0]    status_q;
  logic [3:0]    status_d;

  logic [DW-1:0] op_b;
  logic          cin;
  logic          is_arith;
  logic          defined;
  logic [DW:0]   sum;
  logic [DW-1:0] result;
  logic          ovf;
  logic          status_we;
  logic          load_bubble;

  // Subtraction is folded into the adder as v1 + ~v2 + cin so C is the NOT-borrow.
  always_comb begin
    op_b     = val2;
    cin      = 1'b0;
    is_arith = 1'b0;
    defined  = 1'b1;
    case (exe_cmd)
      CMD_ADD: begin is_arith = 1'b1; end
      CMD_ADC: begin is_arith = 1'b1; cin = status_q[1]; end
      CMD_SUB: begin is_arith = 1'b1; op_b = ~val2; cin = 1'b1; end
      CMD_SBC: begin is_arith = 1'b1; op_b = ~val2; cin = status_q[1]; end
      CMD_MOV, CMD_MVN, CMD_AND, CMD_ORR, CMD_EOR: ;
      default: defined = 1'b0;
    endcase
  end

  assign sum = {1'b0, val1} + {1'b0, op_b} + {{DW{1'b0}}, cin};
  assign ovf = (val1[DW-1] == op_b[DW-1]) && (sum[DW-1] != val1[DW-1]);

  always_comb begin
    result = '0;
    case (exe_cmd)
      CMD_MOV: result = val2;
      CMD_MVN: result = ~val2;
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: result = sum[DW-1:0];
      CMD_AND: result = val1 & val2;
      CMD_ORR: result = val1 | val2;
      CMD_EOR: result = val1 ^ val2;
      default: result = '0;
    endcase
  end

  always_comb begin
    status_d = status_q;
    if (is_arith) begin
      status_d = {result[DW-1], (result == '0), sum[DW], ovf};
    end else begin
      status_d = {result[DW-1], (result == '0), status_q[1:0]};
    end
  end

  assign status_we   = valid_in & s_in & ~freeze & ~flush & defined;
  assign load_bubble = flush | (~freeze & ~valid_in);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_q   <= '0;
      valid_q    <= 1'b0;
      alu_res_q  <= '0;
      st_val_q   <= '0;
      dest_q     <= '0;
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      mem_w_en_q <= 1'b0;
    end else begin
      if (status_we) begin
        status_q <= status_d;
      end
      if (load_bubble) begin
        valid_q    <= 1'b0;
        alu_res_q  <= '0;
        st_val_q   <= '0;
        dest_q     <= '0;
        wb_en_q    <= 1'b0;
        mem_r_en_q <= 1'b0;
        mem_w_en_q <= 1'b0;
      end else if (!freeze) begin
        valid_q    <= 1'b1;
        alu_res_q  <= result;
        st_val_q   <= st_val_in;
        dest_q     <= dest_in;
        wb_en_q    <= wb_en_in & valid_in;
        mem_r_en_q <= mem_r_en_in & valid_in;
        mem_w_en_q <= mem_w_en_in & valid_in;
      end
    end
  end

  assign valid_out    = valid_q;
  assign alu_res_out  = alu_res_q;
  assign st_val_out   = st_val_q;
  assign dest_out     = dest_q;
  assign wb_en_out    = wb_en_q;
  assign mem_r_en_out = mem_r_en_q;
  assign mem_w_en_out = mem_w_en_q;
  assign status_out   = status_q;

endmodule
`default_nettype wire

// File: tb/tb_exe_stage_unit.sv
`default_nettype none
// tb_exe_stage_unit : scoreboard bench; an arithmetic reference model predicts
// the EXE/MEM slot and NZCV after every clock edge.
module tb_exe_stage_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze, flush, valid_in, s_in;
  logic [3:0]  exe_cmd;
  logic [31:0] val1, val2, st_val_in;
  logic [3:0]  dest_in;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in;
  logic        valid_out, wb_en_out, mem_r_en_out, mem_w_en_out;
  logic [31:0] alu_res_out, st_val_out;
  logic [3:0]  dest_out, status_out;

  exe_stage_unit #(.DW(32), .RW(4)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .valid_in(valid_in),
    .exe_cmd(exe_cmd), .s_in(s_in), .val1(val1), .val2(val2), .st_val_in(st_val_in),
    .dest_in(dest_in), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .valid_out(valid_out), .alu_res_out(alu_res_out),
    .st_val_out(st_val_out), .dest_out(dest_out), .wb_en_out(wb_en_out),
    .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out), .status_out(status_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] st;
    logic [3:0]  dest;
    logic        wb;
    logic        mr;
    logic        mw;
    logic [3:0]  status;
  } exp_t;

  exp_t sb_q[$];
  exp_t m;
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  // Reference ALU from the instruction definitions, using 64-bit integer math.
  task automatic ref_alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] st, output logic [31:0] r,
                         output logic [3:0] nzcv, output bit defd);
    longint unsigned ua, ub, full, mask;
    longint sa, sb, ss;
    bit arith;
    logic c;
    ua = a; ub = b; mask = 64'hFFFF_FFFF;
    sa = $signed(a); sb = $signed(b);
    c = st[1];
    arith = 1'b1; defd = 1'b1; full = 0; ss = 0; r = 32'h0;
    case (cmd)
      4'd2: begin full = ua + ub;               ss = sa + sb; end
      4'd3: begin full = ua + ub + c;           ss = sa + sb + c; end
      4'd4: begin full = ua + (mask - ub) + 1;  ss = sa - sb; end
      4'd5: begin full = ua + (mask - ub) + c;  ss = sa - sb - 1 + c; end
      4'd1: begin arith = 1'b0; r = b; end
      4'd9: begin arith = 1'b0; r = ~b; end
      4'd6: begin arith = 1'b0; r = a & b; end
      4'd7: begin arith = 1'b0; r = a | b; end
      4'd8: begin arith = 1'b0; r = a ^ b; end
      default: begin arith = 1'b0; defd = 1'b0; r = 32'h0; end
    endcase
    if (arith) begin
      r = full[31:0];
      nzcv = {r[31], r == 32'h0, full[32],
              (ss > 64'sd2147483647) || (ss < -64'sd2147483648)};
    end else begin
      nzcv = {r[31], r == 32'h0, st[1:0]};
    end
  endtask

  task automatic model_step();
    logic [31:0] r;
    logic [3:0]  nz;
    bit          defd;
    if (!rst) begin
      m = '0;
    end else if (flush || (!freeze && !valid_in)) begin
      m = '{valid: 1'b0, alu: 32'h0, st: 32'h0, dest: 4'h0, wb: 1'b0, mr: 1'b0, mw: 1'b0,
            status: m.status};
    end else if (!freeze) begin
      ref_alu(exe_cmd, val1, val2, m.status, r, nz, defd);
      m.valid = 1'b1;
      m.alu   = r;
      m.st    = st_val_in;
      m.dest  = dest_in;
      m.wb    = wb_en_in;
      m.mr    = mem_r_en_in;
      m.mw    = mem_w_en_in;
      if (s_in && defd) m.status = nz;
    end
  endtask

  task automatic drive(input logic fz, input logic fl, input logic vi, input logic [3:0] cmd,
                       input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] stv, input logic [3:0] d,
                       input logic wb, input logic mr, input logic mw);
    @(negedge clk);
    freeze = fz; flush = fl; valid_in = vi; exe_cmd = cmd; s_in = s;
    val1 = a; val2 = b; st_val_in = stv; dest_in = d;
    wb_en_in = wb; mem_r_en_in = mr; mem_w_en_in = mw;
    @(posedge clk);
    #1;
    model_step();
    sb_q.push_back(m);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk("valid_out",    32'(valid_out),    32'(mon_e.valid));
      chk("alu_res_out",  alu_res_out,       mon_e.alu);
      chk("st_val_out",   st_val_out,        mon_e.st);
      chk("dest_out",     32'(dest_out),     32'(mon_e.dest));
      chk("wb_en_out",    32'(wb_en_out),    32'(mon_e.wb));
      chk("mem_r_en_out", 32'(mem_r_en_out), 32'(mon_e.mr));
      chk("mem_w_en_out", 32'(mem_w_en_out), 32'(mon_e.mw));
      chk("status_out",   32'(status_out),   32'(mon_e.status));
    end
  end

  function automatic logic [31:0] pick();
    logic [31:0] corner [5];
    corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h7FFF_FFFF; corner[4] = 32'h8000_0000;
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; freeze = 1'b1; flush = 1'b0; valid_in = 1'b0; exe_cmd = 4'h0; s_in = 1'b0;
    val1 = 32'h0; val2 = 32'h0; st_val_in = 32'h0; dest_in = 4'h0;
    wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
    m = '0;

    // Reset held with freeze asserted.
    drive(1, 0, 1, 4'd2, 1, 32'd9, 32'd9, 32'h0, 4'd1, 1, 0, 0);
    drive(1, 0, 1, 4'd2, 1, 32'd9, 32'd9, 32'h0, 4'd1, 1, 0, 0);
    rst = 1'b1;

    drive(0, 0, 1, 4'd2, 0, 32'd5, 32'd7, 32'hAA, 4'd3, 1, 0, 0);
    drive(0, 0, 1, 4'd4, 1, 32'd3, 32'd3, 32'h0, 4'd2, 0, 0, 0);
    drive(0, 0, 1, 4'd4, 1, 32'd0, 32'd1, 32'h0, 4'd2, 1, 0, 0);
    drive(0, 0, 1, 4'd2, 1, 32'h7FFF_FFFF, 32'h1, 32'h0, 4'd4, 1, 0, 0);
    drive(0, 0, 1, 4'd3, 0, 32'h0, 32'h0, 32'h0, 4'd5, 1, 0, 0);
    drive(0, 0, 1, 4'd2, 1, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'd4, 1, 0, 0);
    drive(0, 0, 1, 4'd3, 0, 32'h0, 32'h0, 32'h0, 4'd5, 1, 0, 0);
    // Freeze for three cycles, then flush overrides freeze.
    repeat (3) drive(1, 0, 1, 4'd2, 1, 32'h8000_0000, 32'h8000_0000, 32'h5, 4'd6, 1, 0, 1);
    drive(1, 1, 1, 4'd2, 1, 32'h8000_0000, 32'h8000_0000, 32'h5, 4'd6, 1, 0, 1);
    drive(0, 0, 1, 4'd5, 1, 32'd10, 32'd3, 32'h0, 4'd7, 1, 0, 0);
    drive(0, 0, 0, 4'd2, 0, 32'h100, 32'h4, 32'h0, 4'd8, 1, 1, 0);
    drive(0, 0, 1, 4'd15, 1, 32'h123, 32'h456, 32'h0, 4'd8, 1, 0, 0);
    drive(0, 0, 1, 4'd2, 0, 32'h200, 32'h8, 32'hDEAD_BEEF, 4'd9, 0, 0, 1);

    // Asynchronous reset after an S-setting AND.
    drive(0, 0, 1, 4'd6, 1, 32'hF0F0_F0F0, 32'hFF00_0000, 32'h0, 4'd3, 1, 0, 0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_status", 32'(status_out), 32'h0);
    chk("async_rst_valid",  32'(valid_out),  32'h0);
    chk("async_rst_alu",    alu_res_out,     32'h0);
    m = '0;
    @(posedge clk);
    #1;
    sb_q.push_back(m);
    rst = 1'b1;

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 4) != 0), 4'($urandom_range(0, 15)), 1'($urandom),
            pick(), pick(), $urandom, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    @(negedge clk);
    #1;
    chk("scoreboard_drain", 32'(sb_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
